// File: rtl/gppcu_host_cmd_master.sv
`timescale 1ns/1ps
// gppcu_host_cmd_master
//
// Purpose: host-side issuer for the GPPCU test-queue command interface.
// It turns a valid/ready request stream into the strobed command protocol
// on oCMD/oDATA and returns read, status and done-wait results on a
// valid/ready response channel.
//
// Command word layout: CMD[31] strobe, CMD[30:24] op, CMD[23:16] thread,
// CMD[15:0] address. Idle word is 32'h0400_0000 (status op, strobe low).
//
// Handshakes: a beat transfers on a rising iACLK edge where valid and
// ready are both 1. The producer holds its payload stable while valid is
// 1 and not yet accepted; ready never depends combinationally on valid.
//
// Ports:
//   iACLK, inRST              clock, asynchronous active-low reset
//   iREQ_VALID/oREQ_READY     request handshake (ready only in IDLE)
//   iREQ_OP/THREAD/ADDR/WDATA request payload (ops 6/7 illegal)
//   oRSP_VALID/iRSP_READY     response handshake
//   oRSP_DATA                 read data, status word or wait cycle count
//   oERR                      one-cycle pulse on an illegal op
//   oCMD, oDATA               registered drive to target iCMD/iDATA
//   iRDATA, iFULL, iDONE      target oDATA/oFULL/oDONE
//   oPUSH_CNT                 instructions pushed since reset (wraps)
//   oDBG_STATE                current FSM state, for debug/checkers
module gppcu_host_cmd_master #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HIGH_CYC  = 2,
    parameter int unsigned HOLD_CYC  = 2
) (
    input  logic        iACLK,
    input  logic        inRST,
    input  logic        iREQ_VALID,
    output logic        oREQ_READY,
    input  logic [2:0]  iREQ_OP,
    input  logic [7:0]  iREQ_THREAD,
    input  logic [15:0] iREQ_ADDR,
    input  logic [31:0] iREQ_WDATA,
    output logic        oRSP_VALID,
    input  logic        iRSP_READY,
    output logic [31:0] oRSP_DATA,
    output logic        oERR,
    output logic [31:0] oCMD,
    output logic [31:0] oDATA,
    input  logic [31:0] iRDATA,
    input  logic        iFULL,
    input  logic        iDONE,
    output logic [15:0] oPUSH_CNT,
    output logic [2:0]  oDBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_SPACE = 3'd1,
        S_SETUP      = 3'd2,
        S_STROBE     = 3'd3,
        S_HOLD       = 3'd4,
        S_WAIT_DONE  = 3'd5,
        S_RESP       = 3'd6
    } state_e;

    localparam logic [31:0] IDLE_CMD   = 32'h0400_0000;
    localparam logic [2:0]  OP_PUSH    = 3'd0;
    localparam logic [2:0]  OP_RD_LMEM = 3'd1;
    localparam logic [2:0]  OP_RD_STAT = 3'd4;
    localparam logic [2:0]  OP_WAIT    = 3'd5;
    localparam logic [3:0]  SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0]  HIGH_LAST  = 4'(HIGH_CYC - 1);
    localparam logic [3:0]  HOLD_LAST  = 4'(HOLD_CYC - 1);

    state_e      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] cmd_q, cmd_d;
    logic [31:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        err_q, err_d;
    logic [15:0] push_cnt_q, push_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            op_q        <= '0;
            cmd_q       <= IDLE_CMD;
            data_q      <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            push_cnt_q  <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            op_q        <= op_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            push_cnt_q  <= push_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        op_d        = op_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        err_d       = 1'b0;
        push_cnt_d  = push_cnt_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                // ready_q is only ever 1 in IDLE, so it qualifies the accept.
                if (iREQ_VALID && ready_q) begin
                    op_d = iREQ_OP;
                    if (iREQ_OP <= OP_RD_STAT) begin
                        cmd_d   = {1'b0, 4'b0, iREQ_OP, iREQ_THREAD, iREQ_ADDR};
                        data_d  = iREQ_WDATA;
                        phase_d = '0;
                        // A push into a full queue parks with fields driven.
                        state_d = (iREQ_OP == OP_PUSH && iFULL) ? S_WAIT_SPACE : S_SETUP;
                    end else if (iREQ_OP == OP_WAIT) begin
                        wait_cnt_d = '0;
                        state_d    = S_WAIT_DONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT_SPACE: begin
                if (!iFULL) begin
                    phase_d = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_q == SETUP_LAST) begin
                    phase_d   = '0;
                    cmd_d[31] = 1'b1;
                    state_d   = S_STROBE;
                    if (op_q == OP_PUSH) begin
                        push_cnt_d = push_cnt_q + 16'd1;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            S_STROBE: begin
                if (phase_q == HIGH_LAST) begin
                    phase_d   = '0;
                    cmd_d[31] = 1'b0;
                    state_d   = S_HOLD;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (phase_q == HOLD_LAST) begin
                    phase_d = '0;
                    cmd_d   = IDLE_CMD;
                    // Target read data is valid by the end of the hold window.
                    if (op_q == OP_RD_LMEM || op_q == OP_RD_STAT) begin
                        rsp_data_d  = iRDATA;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            S_WAIT_DONE: begin
                if (iDONE) begin
                    rsp_data_d  = wait_cnt_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (wait_cnt_q != 32'hFFFF_FFFF) begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            S_RESP: begin
                if (iRSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                cmd_d   = IDLE_CMD;
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    assign oREQ_READY = ready_q;
    assign oRSP_VALID = rsp_valid_q;
    assign oRSP_DATA  = rsp_data_q;
    assign oERR       = err_q;
    assign oCMD       = cmd_q;
    assign oDATA      = data_q;
    assign oPUSH_CNT  = push_cnt_q;
    assign oDBG_STATE = state_q;

endmodule
